// File: rtl/fifo_sync_param_if.sv
// -----------------------------------------------------------------------------
// fifo_sync_param_if
// Bundles the producer/consumer-facing signals of fifo_sync_param.
//   slave  : the FIFO side (takes requests, drives data and status)
//   master : the user side (drives requests, observes data and status)
// Signals:
//   flush, clr_err          control requests
//   wr_en, din              write request and data
//   rd_en                   read (pop) request
//   dout, dout_valid        read data and its qualifier
//   full, empty             occupancy extremes
//   almost_full/_empty      threshold flags
//   count                   occupancy 0..DEPTH
//   overflow, underflow     sticky error flags
// -----------------------------------------------------------------------------
interface fifo_sync_param_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
);
   logic                  flush;
   logic                  clr_err;
   logic                  wr_en;
   logic [DATA_WIDTH-1:0] din;
   logic                  rd_en;
   logic [DATA_WIDTH-1:0] dout;
   logic                  dout_valid;
   logic                  full;
   logic                  empty;
   logic                  almost_full;
   logic                  almost_empty;
   logic [ADDR_WIDTH:0]   count;
   logic                  overflow;
   logic                  underflow;

   modport slave (
      input  flush, clr_err, wr_en, din, rd_en,
      output dout, dout_valid, full, empty, almost_full, almost_empty,
             count, overflow, underflow
   );

   modport master (
      output flush, clr_err, wr_en, din, rd_en,
      input  dout, dout_valid, full, empty, almost_full, almost_empty,
             count, overflow, underflow
   );
endinterface

// File: rtl/fifo_sync_param.sv
// -----------------------------------------------------------------------------
// fifo_sync_param
// Single-clock FIFO owning its storage, pointers, occupancy counter and flags.
// Supports a registered (FWFT=0) or first-word-fall-through (FWFT=1) read
// port, programmable almost-full/almost-empty thresholds, synchronous flush
// and sticky overflow/underflow flags.
// Ports:
//   clk  : clock, all state updates on the rising edge
//   rst  : synchronous active-high reset, highest priority
//   bus  : fifo_sync_param_if.slave (requests in, data/status out)
// -----------------------------------------------------------------------------
module fifo_sync_param #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int FWFT       = 0,
   parameter int AF_THRESH  = 14,
   parameter int AE_THRESH  = 2
) (
   input logic               clk,
   input logic               rst,
   fifo_sync_param_if.slave  bus
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] CNT_FULL = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] CNT_AF   = (ADDR_WIDTH + 1)'(AF_THRESH);
   localparam logic [ADDR_WIDTH:0] CNT_AE   = (ADDR_WIDTH + 1)'(AE_THRESH);
   localparam logic [ADDR_WIDTH:0] CNT_ONE  = (ADDR_WIDTH + 1)'(1);
   localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

   if (!(AE_THRESH >= 0 && AE_THRESH < AF_THRESH && AF_THRESH <= DEPTH)) begin : g_bad_thresh
      $error("fifo_sync_param: thresholds must satisfy 0 <= AE_THRESH < AF_THRESH <= DEPTH");
   end

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH:0]   count_q,  count_d;
   logic                  ovf_q,    ovf_d;
   logic                  unf_q,    unf_d;

   logic full, empty;
   logic wr_acc, rd_acc;

   // Full/empty come from the occupancy counter so that equal pointers are
   // never ambiguous.
   assign full  = (count_q == CNT_FULL);
   assign empty = (count_q == '0);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      // Acceptance uses only the pre-edge flags: a same-cycle read never
      // frees room for a write into a full FIFO, and vice versa.
      wr_acc   = bus.wr_en & ~full  & ~bus.flush;
      rd_acc   = bus.rd_en & ~empty & ~bus.flush;
      ovf_d    = ovf_q & ~bus.clr_err;
      unf_d    = unf_q & ~bus.clr_err;

      if (bus.flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
         case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
         // A fresh error overrides a same-cycle clear.
         if (bus.wr_en & full)  ovf_d = 1'b1;
         if (bus.rd_en & empty) unf_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
      end
   end

   // Storage is deliberately not reset; stale words are unreachable once the
   // pointers and count are cleared.
   always_ff @(posedge clk) begin
      if (wr_acc && !rst) mem_q[wr_ptr_q] <= bus.din;
   end

   if (FWFT != 0) begin : g_fwft
      // Head word is shown directly from storage whenever anything is held.
      assign bus.dout       = mem_q[rd_ptr_q];
      assign bus.dout_valid = ~empty;
   end else begin : g_std
      logic [DATA_WIDTH-1:0] dout_q;
      logic                  dout_vld_q;

      always_ff @(posedge clk) begin
         if (rst) begin
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
         end else begin
            dout_vld_q <= rd_acc;
            if (rd_acc) dout_q <= mem_q[rd_ptr_q];
         end
      end

      assign bus.dout       = dout_q;
      assign bus.dout_valid = dout_vld_q;
   end

   assign bus.full         = full;
   assign bus.empty        = empty;
   assign bus.almost_full  = (count_q >= CNT_AF);
   assign bus.almost_empty = (count_q <= CNT_AE);
   assign bus.count        = count_q;
   assign bus.overflow     = ovf_q;
   assign bus.underflow    = unf_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// -----------------------------------------------------------------------------
// tb_fifo_sync_param
// Drives a standard-mode and an FWFT-mode fifo_sync_param with identical
// stimulus and compares both against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_fifo_sync_param;

   localparam int DW    = 8;
   localparam int AW    = 4;
   localparam int DEPTH = 16;
   localparam int AF    = 14;
   localparam int AE    = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          d_rst   = 1'b0;
   logic          d_flush = 1'b0;
   logic          d_clr   = 1'b0;
   logic          d_wr    = 1'b0;
   logic          d_rd    = 1'b0;
   logic [DW-1:0] d_din   = '0;

   fifo_sync_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) s_if ();
   fifo_sync_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) f_if ();

   assign s_if.flush = d_flush;  assign f_if.flush = d_flush;
   assign s_if.clr_err = d_clr;  assign f_if.clr_err = d_clr;
   assign s_if.wr_en = d_wr;     assign f_if.wr_en = d_wr;
   assign s_if.rd_en = d_rd;     assign f_if.rd_en = d_rd;
   assign s_if.din = d_din;      assign f_if.din = d_din;

   fifo_sync_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(0),
                     .AF_THRESH(AF), .AE_THRESH(AE))
      u_std (.clk(clk), .rst(d_rst), .bus(s_if));

   fifo_sync_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1),
                     .AF_THRESH(AF), .AE_THRESH(AE))
      u_fwft (.clk(clk), .rst(d_rst), .bus(f_if));

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [DW-1:0] q [$];
   logic [DW-1:0] m_dout = '0;
   bit            m_vld  = 0;
   bit            m_ovf  = 0;
   bit            m_unf  = 0;
   bit            m_live = 0;
   bit            m_wa, m_ra;

   always @(posedge clk) begin
      if (d_rst) begin
         q.delete();
         m_dout = '0;
         m_vld  = 0;
         m_ovf  = 0;
         m_unf  = 0;
         m_live = 1;
      end else if (d_flush) begin
         q.delete();
         m_vld = 0;
         if (d_clr) begin m_ovf = 0; m_unf = 0; end
      end else begin
         m_wa = d_wr && (q.size() < DEPTH);
         m_ra = d_rd && (q.size() > 0);
         if (d_clr) begin m_ovf = 0; m_unf = 0; end
         if (d_wr && !m_wa) m_ovf = 1;
         if (d_rd && !m_ra) m_unf = 1;
         m_vld = m_ra;
         if (m_ra) m_dout = q.pop_front();
         if (m_wa) q.push_back(d_din);
      end
   end

   // Compare both DUTs to the model on the falling edge.
   always @(negedge clk) begin
      if (m_live) begin
         chk("s_count", 32'(s_if.count), 32'(q.size()));
         chk("s_full",  32'(s_if.full),  32'(q.size() == DEPTH));
         chk("s_empty", 32'(s_if.empty), 32'(q.size() == 0));
         chk("s_afull", 32'(s_if.almost_full),  32'(q.size() >= AF));
         chk("s_aempty", 32'(s_if.almost_empty), 32'(q.size() <= AE));
         chk("s_ovf",   32'(s_if.overflow),  32'(m_ovf));
         chk("s_unf",   32'(s_if.underflow), 32'(m_unf));
         chk("s_vld",   32'(s_if.dout_valid), 32'(m_vld));
         chk("s_dout",  32'(s_if.dout), 32'(m_dout));
         chk("f_count", 32'(f_if.count), 32'(q.size()));
         chk("f_ovf",   32'(f_if.overflow),  32'(m_ovf));
         chk("f_unf",   32'(f_if.underflow), 32'(m_unf));
         chk("f_vld",   32'(f_if.dout_valid), 32'(q.size() > 0));
         if (q.size() > 0) chk("f_dout", 32'(f_if.dout), 32'(q[0]));
      end
   end

   // One clock: apply inputs, wait for the edge, settle 1 time unit.
   task automatic cyc(input bit wr, input logic [DW-1:0] din, input bit rd,
                      input bit fl = 0, input bit clr = 0, input bit rs = 0);
      d_wr = wr; d_din = din; d_rd = rd; d_flush = fl; d_clr = clr; d_rst = rs;
      @(posedge clk);
      #1;
      d_wr = 0; d_rd = 0; d_flush = 0; d_clr = 0; d_rst = 0;
   endtask

   initial begin
      int nw;
      @(negedge clk);

      // Reset state
      cyc(0, 0, 0, 0, 0, 1);
      chk("rst_count", 32'(s_if.count), 0);
      chk("rst_empty", 32'(s_if.empty), 1);
      chk("rst_aempty", 32'(s_if.almost_empty), 1);
      chk("rst_dout", 32'(s_if.dout), 0);

      // 1: fill with 0x00..0x0F
      for (int i = 0; i < 16; i++) begin
         cyc(1, DW'(i), 0);
         chk("t1_aempty", 32'(s_if.almost_empty), 32'((i + 1) <= 2));
         chk("t1_afull",  32'(s_if.almost_full),  32'((i + 1) >= 14));
      end
      chk("t1_count", 32'(s_if.count), 16);
      chk("t1_full", 32'(s_if.full), 1);

      // 2: overflow then drain
      cyc(1, 8'hAA, 0);
      chk("t2_count", 32'(s_if.count), 16);
      chk("t2_ovf", 32'(s_if.overflow), 1);
      for (int i = 0; i < 16; i++) begin
         cyc(0, 0, 1);
         chk("t2_vld", 32'(s_if.dout_valid), 1);
         chk("t2_dout", 32'(s_if.dout), 32'(i));
      end
      cyc(0, 0, 0);
      chk("t2_vld_end", 32'(s_if.dout_valid), 0);
      chk("t2_ovf_hold", 32'(s_if.overflow), 1);
      cyc(0, 0, 0, 0, 1);
      chk("t2_clr", 32'(s_if.overflow), 0);

      // 3: wrap across address 15 -> 0
      for (int i = 0; i < 10; i++) cyc(1, DW'(8'h10 + i), 0);
      for (int i = 0; i < 10; i++) cyc(0, 0, 1);
      for (int i = 0; i < 12; i++) cyc(1, DW'(8'h20 + i), 0);
      for (int i = 0; i < 12; i++) begin
         cyc(0, 0, 1);
         chk("t3_dout", 32'(s_if.dout), 32'(8'h20 + i));
      end
      chk("t3_empty", 32'(s_if.empty), 1);

      // 4: simultaneous read/write
      for (int i = 0; i < 5; i++) cyc(1, DW'(8'h40 + i), 0);
      for (int i = 0; i < 3; i++) begin
         cyc(1, DW'(8'h50 + i), 1);
         chk("t4_count", 32'(s_if.count), 5);
         chk("t4_dout", 32'(s_if.dout), 32'(8'h40 + i));
      end
      for (int i = 0; i < 5; i++) begin
         cyc(0, 0, 1);
         chk("t4_order", 32'(s_if.dout), (i < 2) ? 32'(8'h43 + i) : 32'(8'h50 + i - 2));
      end
      cyc(1, 8'h60, 1);
      chk("t4_unf", 32'(s_if.underflow), 1);
      chk("t4_cnt1", 32'(s_if.count), 1);
      chk("t4_vld0", 32'(s_if.dout_valid), 0);
      cyc(0, 0, 1, 0, 1);

      // 5: FWFT fall-through
      cyc(0, 0, 0, 0, 0, 1);
      cyc(1, 8'h5A, 0);
      chk("t5_fdout", 32'(f_if.dout), 32'h5A);
      chk("t5_fvld", 32'(f_if.dout_valid), 1);
      cyc(0, 0, 1);
      chk("t5_fempty", 32'(f_if.empty), 1);
      chk("t5_fvld0", 32'(f_if.dout_valid), 0);
      chk("t5_sdout", 32'(s_if.dout), 32'h5A);

      // 6: flush with same-cycle write, then reset mid-burst
      for (int i = 0; i < 7; i++) cyc(1, DW'(8'h70 + i), 0);
      cyc(1, 8'h77, 0, 1);
      chk("t6_count", 32'(s_if.count), 0);
      chk("t6_empty", 32'(s_if.empty), 1);
      chk("t6_ovf", 32'(s_if.overflow), 0);
      cyc(0, 0, 1);
      chk("t6_unf", 32'(s_if.underflow), 1);
      for (int i = 0; i < 3; i++) cyc(1, DW'(8'h80 + i), 0);
      cyc(1, 8'h83, 1, 0, 0, 1);
      chk("t6r_count", 32'(s_if.count), 0);
      chk("t6r_unf", 32'(s_if.underflow), 0);
      chk("t6r_dout", 32'(s_if.dout), 0);
      chk("t6r_vld", 32'(s_if.dout_valid), 0);
      chk("t6r_fvld", 32'(f_if.dout_valid), 0);
      cyc(1, 8'h99, 0);
      chk("t6r_fdout", 32'(f_if.dout), 32'h99);
      cyc(0, 0, 1);
      chk("t6r_sdout", 32'(s_if.dout), 32'h99);

      // Random phases with varying write/read bias
      for (int ph = 0; ph < 15; ph++) begin
         int pw, pr;
         pw = $urandom_range(10, 90);
         pr = $urandom_range(10, 90);
         for (int i = 0; i < 200; i++) begin
            nw = $urandom_range(0, 99);
            cyc(nw < pw, DW'($urandom), $urandom_range(0, 99) < pr,
                $urandom_range(0, 63) == 0, $urandom_range(0, 31) == 0,
                $urandom_range(0, 499) == 0);
         end
      end

      @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/fifo_sync_param.md
Name: fifo_sync_param

Overview:
- Self-contained synchronous FIFO: owns its storage array, write/read pointers, occupancy counter and status flags, so callers no longer drive pointers.
- Adds programmable almost-full/almost-empty thresholds, selectable standard or first-word-fall-through (FWFT) read mode, synchronous flush, and sticky overflow/underflow error flags.
- Sits between producer and consumer blocks in a single clock domain.

Parameters:
- DATA_WIDTH, 8, word width in bits.
- ADDR_WIDTH, 4, pointer width; DEPTH = 2**ADDR_WIDTH entries.
- FWFT, 0, read mode: 0 = standard registered read, 1 = first-word-fall-through.
- AF_THRESH, 14, almost_full asserts when count >= AF_THRESH.
- AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH.
- Legal range: 0 <= AE_THRESH < AF_THRESH <= DEPTH. Out-of-range values are a static elaboration error.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  synchronous clear of FIFO contents.
- wr_en  in  1  write request.
- din  in  DATA_WIDTH  write data.
- rd_en  in  1  read (pop) request.
- dout  out  DATA_WIDTH  read data.
- dout_valid  out  1  dout holds a valid popped/head word.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_THRESH.
- almost_empty  out  1  count <= AE_THRESH.
- count  out  ADDR_WIDTH+1  occupancy, 0..DEPTH.
- overflow  out  1  sticky: a write was rejected.
- underflow  out  1  sticky: a read was rejected.
- clr_err  in  1  clears overflow/underflow.

Behaviour:
- Reset (rst=1 at an edge): wr_ptr=0, rd_ptr=0, count=0, dout=0, dout_valid=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0. Memory contents are not cleared. rst has priority over every other input.
- Write acceptance:
  - A write is accepted only when wr_en=1 and full=0 at the edge. Accepted: mem[wr_ptr] <= din, wr_ptr increments modulo DEPTH.
  - wr_en=1 with full=1: write dropped, overflow <= 1. A same-cycle read does not make room for the write.
- Read acceptance:
  - A read is accepted only when rd_en=1 and empty=0. Accepted: rd_ptr increments modulo DEPTH.
  - rd_en=1 with empty=1: no pop, underflow <= 1. A same-cycle write does not satisfy the read.
- Count update: +1 on write-only, -1 on read-only, unchanged when both are accepted or neither is. All flags are derived from the registered count, so they change on the edge after the causing operation.
- Standard mode (FWFT=0):
  - On an accepted read, dout <= mem[rd_ptr] at the same edge and dout_valid <= 1 for exactly one cycle.
  - Otherwise dout holds its last value and dout_valid <= 0.
  - Read latency: 1 cycle.
- FWFT mode (FWFT=1):
  - dout = mem[rd_ptr], combinational from storage; dout_valid = ~empty.
  - A word written into an empty FIFO appears on dout with dout_valid=1 in the cycle after the write edge.
  - rd_en pops the shown word; the next word appears after the edge.
- flush=1 (no rst): pointers=0, count=0, dout_valid=0. Same-cycle wr_en and rd_en are ignored; no error flags are set. overflow/underflow and dout are otherwise unchanged.
- clr_err=1: overflow <= 0 and underflow <= 0. If a new error occurs in the same cycle, the set wins.
- Pointer wrap: DEPTH-1 -> 0 with no gap; full and empty are distinguished by count, never by pointer equality alone.
- Reset mid-operation: all pending data is discarded; the first post-reset write lands at address 0.

Test Plan (defaults: DEPTH=16, AF=14, AE=2, FWFT=0 unless noted):
1. Reset, then write 0x00..0x0F on 16 consecutive cycles -> almost_empty drops when count=3; almost_full rises when count=14; full=1 and count=16 after the 16th edge.
2. From full, write 0xAA -> count stays 16, overflow=1 and stays set. Then read 16 times -> dout sequence 0x00..0x0F, each with a one-cycle dout_valid pulse one cycle after rd_en; 0xAA never appears. Pulse clr_err -> overflow=0.
3. Wrap: write/read 10 words, then write 0x20..0x2B (crossing address 15->0) and read all -> output 0x20..0x2B in order; empty=1 at end.
4. At count=5, assert wr_en and rd_en together for 3 cycles -> count stays 5 and data order is preserved. From empty, assert wr_en+rd_en -> underflow=1, count=1, dout_valid stays 0.
5. FWFT=1 instance: write 0x5A into empty -> next cycle dout=0x5A, dout_valid=1. Then rd_en=1 -> after the edge empty=1, dout_valid=0.
6. At count=7, assert flush with wr_en=1 (din=0x77) -> count=0, empty=1, no overflow; next read underflows. Repeat using rst mid-burst -> all outputs at reset values; the next write/read returns the new data.
